// File: rtl/register_writeback_queue_if.sv
// Bundles the producer, bank write port and forwarding lookup signals of the writeback queue.
// The master is the pipeline/bank environment. The slave is the queue itself.
interface register_writeback_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_address;
    logic [DATA_WIDTH-1:0] in_data;

    logic                  bank_stall;
    logic                  bank_write;
    logic [ADDR_WIDTH-1:0] bank_address;
    logic [DATA_WIDTH-1:0] bank_data;

    logic [ADDR_WIDTH-1:0] lookup_address_1;
    logic [ADDR_WIDTH-1:0] lookup_address_2;
    logic                  lookup_hit_1;
    logic                  lookup_hit_2;
    logic [DATA_WIDTH-1:0] lookup_data_1;
    logic [DATA_WIDTH-1:0] lookup_data_2;

    logic [CW-1:0]         occupancy;

    modport master (
        output in_valid, in_address, in_data, bank_stall, lookup_address_1, lookup_address_2,
        input  in_ready, bank_write, bank_address, bank_data,
        input  lookup_hit_1, lookup_hit_2, lookup_data_1, lookup_data_2, occupancy
    );

    modport slave (
        input  in_valid, in_address, in_data, bank_stall, lookup_address_1, lookup_address_2,
        output in_ready, bank_write, bank_address, bank_data,
        output lookup_hit_1, lookup_hit_2, lookup_data_1, lookup_data_2, occupancy
    );
endinterface

// File: rtl/register_writeback_queue.sv
// Purpose: FIFO of pending register writes feeding the bank write port, with forwarding lookup (WRITEBACK_BYPASS_EN).
// Latency: an entry accepted into an empty queue is presented to the bank on the next cycle.
// Backpressure: in_ready = not-full (registered count only); bank_stall holds the head entry.
module register_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input logic                        clock,
    input logic                        reset_n,
    register_writeback_queue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(31);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic accept;
    logic push;
    logic drain;

    assign bus.in_ready     = (count != CW'(DEPTH));
    assign accept           = bus.in_valid && bus.in_ready;
    assign push             = accept && (bus.in_address != XZR);
    assign drain            = (count != '0) && !bus.bank_stall;
    assign bus.bank_write   = drain;
    assign bus.bank_address = addr_q[head];
    assign bus.bank_data    = data_q[head];
    assign bus.occupancy    = count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            if (drain)
                head <= head + PW'(1);
            count <= count + CW'(push) - CW'(drain);
        end
    end

    // Entry payload carries no reset; count alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_q[tail] <= bus.in_address;
            data_q[tail] <= bus.in_data;
        end
    end

`ifdef WRITEBACK_BYPASS_EN
    logic                  hit_1;
    logic                  hit_2;
    logic [DATA_WIDTH-1:0] fwd_1;
    logic [DATA_WIDTH-1:0] fwd_2;
    logic [PW-1:0]         idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit_1 = 1'b0;
        hit_2 = 1'b0;
        fwd_1 = '0;
        fwd_2 = '0;
        idx   = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (addr_q[idx] == bus.lookup_address_1 && bus.lookup_address_1 != XZR) begin
                    hit_1 = 1'b1;
                    fwd_1 = data_q[idx];
                end
                if (addr_q[idx] == bus.lookup_address_2 && bus.lookup_address_2 != XZR) begin
                    hit_2 = 1'b1;
                    fwd_2 = data_q[idx];
                end
            end
        end
    end

    assign bus.lookup_hit_1  = hit_1;
    assign bus.lookup_hit_2  = hit_2;
    assign bus.lookup_data_1 = fwd_1;
    assign bus.lookup_data_2 = fwd_2;
`else
    logic unused_lookup;

    assign unused_lookup     = ^{bus.lookup_address_1, bus.lookup_address_2};
    assign bus.lookup_hit_1  = 1'b0;
    assign bus.lookup_hit_2  = 1'b0;
    assign bus.lookup_data_1 = '0;
    assign bus.lookup_data_2 = '0;
`endif
endmodule
